cvmcu_cpi_frame_gen: RTL and testbench

//   Synthesizable camera-side CPI source: generates vsync/href/pixel-data frames with programmable

---
 rtl/cvmcu_cpi_frame_gen.sv | 193 +++++++++++++++++++
 tb/tb_cvmcu_cpi_frame_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cvmcu_cpi_frame_gen.sv
// Camera-side CPI source: emits vsync/href/pixel frames with latched geometry, fixed porches and test patterns.
// Outputs are a registered decode of the FSM state, so every pin lags the state register by one cycle.
module cvmcu_cpi_frame_gen #(
  parameter int DATA_W     = 10,
  parameter int DIM_W      = 12,
  parameter int VSYNC_CYC  = 4,
  parameter int VBP_CYC    = 8,
  parameter int HBLANK_CYC = 4,
  parameter int VFP_CYC    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic [DIM_W-1:0]  line_w_i,
  input  logic [DIM_W-1:0]  lines_i,
  input  logic [1:0]        pattern_i,
  input  logic [DATA_W-1:0] fill_i,
  output logic              cpi_vsync_o,
  output logic              cpi_href_o,
  output logic [DATA_W-1:0] cpi_data_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [15:0]       frame_cnt_o
);

  localparam int PC_W = 16;
  localparam logic [PC_W-1:0] VSYNC_LAST  = PC_W'(VSYNC_CYC - 1);
  localparam logic [PC_W-1:0] VBP_LAST    = PC_W'(VBP_CYC - 1);
  localparam logic [PC_W-1:0] HBLANK_LAST = PC_W'(HBLANK_CYC - 1);
  localparam logic [PC_W-1:0] VFP_LAST    = PC_W'(VFP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_HBLANK, S_VFP
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   cyc_q, cyc_d;
  logic [DIM_W-1:0]  col_q, col_d, row_q, row_d;
  logic [DIM_W-1:0]  line_w_q, line_w_d, lines_q, lines_d;
  logic [1:0]        pattern_q, pattern_d;
  logic [DATA_W-1:0] fill_q, fill_d, pix_q, pix_d;
  logic              latch_cfg;

  logic              vsync_q, vsync_d, href_q, href_d, busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    col_d     = col_q;
    row_d     = row_q;
    pix_d     = pix_q;
    latch_cfg = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (en_i) begin
          state_d   = S_VSYNC;
          cyc_d     = '0;
          latch_cfg = 1'b1;
        end
      end
      S_VSYNC: begin
        if (cyc_q == VSYNC_LAST) begin
          state_d = S_VBP;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + PC_W'(1);
        end
      end
      S_VBP: begin
        if (cyc_q == VBP_LAST) begin
          state_d = S_ACTIVE;
          col_d   = '0;
          row_d   = '0;
          pix_d   = '0;
        end else begin
          cyc_d = cyc_q + PC_W'(1);
        end
      end
      S_ACTIVE: begin
        pix_d = pix_q + DATA_W'(1);
        if (col_q == line_w_q - DIM_W'(1)) begin
          col_d = '0;
          cyc_d = '0;
          if (row_q == lines_q - DIM_W'(1)) begin
            state_d = S_VFP;
          end else begin
            state_d = S_HBLANK;
            row_d   = row_q + DIM_W'(1);
          end
        end else begin
          col_d = col_q + DIM_W'(1);
        end
      end
      S_HBLANK: begin
        if (cyc_q == HBLANK_LAST) begin
          state_d = S_ACTIVE;
        end else begin
          cyc_d = cyc_q + PC_W'(1);
        end
      end
      S_VFP: begin
        if (cyc_q == VFP_LAST) begin
          cyc_d = '0;
          if (en_i) begin
            state_d   = S_VSYNC;
            latch_cfg = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cyc_d = cyc_q + PC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Zero geometry is promoted to 1 at latch time so the compare logic never sees 0.
  always_comb begin
    line_w_d  = line_w_q;
    lines_d   = lines_q;
    pattern_d = pattern_q;
    fill_d    = fill_q;
    if (latch_cfg) begin
      line_w_d  = (line_w_i == '0) ? DIM_W'(1) : line_w_i;
      lines_d   = (lines_i == '0) ? DIM_W'(1) : lines_i;
      pattern_d = pattern_i;
      fill_d    = fill_i;
    end
  end

  always_comb begin
    vsync_d     = (state_q == S_VSYNC);
    href_d      = (state_q == S_ACTIVE);
    busy_d      = (state_q != S_IDLE);
    done_d      = (state_q == S_VFP) && (cyc_q == VFP_LAST);
    frame_cnt_d = frame_cnt_q + {15'd0, done_d};
    data_d      = '0;
    if (state_q == S_ACTIVE) begin
      unique case (pattern_q)
        2'd0:    data_d = pix_q;
        2'd2:    data_d = {DATA_W{row_q[0] ^ col_q[0]}};
        default: data_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pix_q       <= '0;
      line_w_q    <= '0;
      lines_q     <= '0;
      pattern_q   <= '0;
      fill_q      <= '0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pix_q       <= pix_d;
      line_w_q    <= line_w_d;
      lines_q     <= lines_d;
      pattern_q   <= pattern_d;
      fill_q      <= fill_d;
      vsync_q     <= vsync_d;
      href_q      <= href_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign cpi_vsync_o  = vsync_q;
  assign cpi_href_o   = href_q;
  assign cpi_data_o   = data_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_cvmcu_cpi_frame_gen.sv
// Bench for cvmcu_cpi_frame_gen: a per-cycle expected pin stream is built from frame geometry
// and compared against the DUT pins on every falling edge.
module tb_cvmcu_cpi_frame_gen;

  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HB = 2;
  localparam int VF = 1;

  logic        clk;
  logic        reset;
  logic        en_i;
  logic [11:0] line_w_i;
  logic [11:0] lines_i;
  logic [1:0]  pattern_i;
  logic [9:0]  fill_i;
  logic        cpi_vsync_o;
  logic        cpi_href_o;
  logic [9:0]  cpi_data_o;
  logic        busy_o;
  logic        frame_done_o;
  logic [15:0] frame_cnt_o;

  cvmcu_cpi_frame_gen #(
    .DATA_W(10), .DIM_W(12), .VSYNC_CYC(VS), .VBP_CYC(VB), .HBLANK_CYC(HB), .VFP_CYC(VF)
  ) dut (
    .clk(clk), .reset(reset), .en_i(en_i), .line_w_i(line_w_i), .lines_i(lines_i),
    .pattern_i(pattern_i), .fill_i(fill_i), .cpi_vsync_o(cpi_vsync_o), .cpi_href_o(cpi_href_o),
    .cpi_data_o(cpi_data_o), .busy_o(busy_o), .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       vs;
    logic       hr;
    logic [9:0] d;
    logic       dn;
    logic       bz;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_cnt;
  logic [15:0] cnt0;
  int          checks;
  int          failures;
  bit          scramble;

  function automatic exp_t mk(input logic vs, input logic hr, input logic [9:0] d,
                              input logic dn, input logic bz);
    exp_t e;
    e.vs = vs; e.hr = hr; e.d = d; e.dn = dn; e.bz = bz;
    return e;
  endfunction

  task automatic check(input string tag, input logic [29:0] obs, input logic [29:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected pin stream of one whole frame, one entry per output cycle.
  task automatic add_frame(input int lw, input int ln, input int pat, input logic [9:0] fill);
    int w, h, idx;
    logic [9:0] d;
    w = (lw == 0) ? 1 : lw;
    h = (ln == 0) ? 1 : ln;
    for (int i = 0; i < VS; i++) exp_q.push_back(mk(1'b1, 1'b0, 10'd0, 1'b0, 1'b1));
    for (int i = 0; i < VB; i++) exp_q.push_back(mk(1'b0, 1'b0, 10'd0, 1'b0, 1'b1));
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        idx = r * w + c;
        if (pat == 0)      d = 10'(idx);
        else if (pat == 2) d = (((r ^ c) & 1) != 0) ? 10'h3FF : 10'h000;
        else               d = fill;
        exp_q.push_back(mk(1'b0, 1'b1, d, 1'b0, 1'b1));
      end
      if (r < h - 1)
        for (int i = 0; i < HB; i++) exp_q.push_back(mk(1'b0, 1'b0, 10'd0, 1'b0, 1'b1));
    end
    for (int i = 0; i < VF - 1; i++) exp_q.push_back(mk(1'b0, 1'b0, 10'd0, 1'b0, 1'b1));
    exp_q.push_back(mk(1'b0, 1'b0, 10'd0, 1'b1, 1'b1));
  endtask

  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = mk(1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    if (e.dn) exp_cnt++;
    check(tag, {cpi_vsync_o, cpi_href_o, cpi_data_o, frame_done_o, busy_o, frame_cnt_o},
          {e.vs, e.hr, e.d, e.dn, e.bz, exp_cnt});
    if (scramble) begin
      line_w_i  = 12'($urandom);
      lines_i   = 12'($urandom);
      pattern_i = 2'($urandom);
      fill_i    = 10'($urandom);
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic drain(input string tag);
    int n;
    n = exp_q.size() + 2;
    run(n, tag);
  endtask

  task automatic set_cfg(input int lw, input int ln, input int pat, input logic [9:0] fill);
    line_w_i  = 12'(lw);
    lines_i   = 12'(ln);
    pattern_i = 2'(pat);
    fill_i    = fill;
  endtask

  // Single-cycle en pulse: one idle output cycle of latency, then the whole frame.
  task automatic pulse_frame(input int lw, input int ln, input int pat, input logic [9:0] fill,
                             input bit scr, input string tag);
    set_cfg(lw, ln, pat, fill);
    en_i = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 10'd0, 1'b0, 1'b0));
    add_frame(lw, ln, pat, fill);
    step(tag);
    en_i = 1'b0;
    scramble = scr;
    drain(tag);
    scramble = 1'b0;
  endtask

  initial begin
    int l1, lw, ln;
    checks   = 0;
    failures = 0;
    exp_cnt  = '0;
    scramble = 1'b0;
    reset    = 1'b1;
    en_i     = 1'b0;
    set_cfg(0, 0, 0, 10'd0);
    repeat (2) @(negedge clk);
    check("reset_state", {cpi_vsync_o, cpi_href_o, cpi_data_o, frame_done_o, busy_o, frame_cnt_o}, 30'd0);
    reset = 1'b0;
    run(3, "idle");

    pulse_frame(4, 2, 0, 10'd0, 1'b0, "pulse_4x2_inc");

    // Three back-to-back frames; en dropped once the third frame has started.
    cnt0 = exp_cnt;
    l1 = VS + VB + 9 + 2 * HB + VF;
    set_cfg(3, 3, 0, 10'd0);
    en_i = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 10'd0, 1'b0, 1'b0));
    add_frame(3, 3, 0, 10'd0);
    add_frame(3, 3, 0, 10'd0);
    add_frame(3, 3, 0, 10'd0);
    run(2 * l1 + 2, "b2b_3x3");
    en_i = 1'b0;
    drain("b2b_3x3");
    check("b2b_frame_cnt", {14'd0, frame_cnt_o}, {14'd0, cnt0 + 16'd3});

    // Config changes mid-frame apply only from the next frame.
    l1 = VS + VB + 6 + HB + VF;
    set_cfg(3, 2, 1, 10'h2A5);
    en_i = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 10'd0, 1'b0, 1'b0));
    add_frame(3, 2, 1, 10'h2A5);
    add_frame(5, 2, 1, 10'h111);
    run(6, "fill_latch");
    fill_i   = 10'h111;
    line_w_i = 12'd5;
    run(l1 - 4, "fill_latch");
    en_i = 1'b0;
    drain("fill_latch");

    pulse_frame(2, 2, 2, 10'd0, 1'b0, "checker_2x2");
    pulse_frame(3, 3, 3, 10'h155, 1'b0, "reserved_fill");

    // Counter wrap from a preset of 0xFFFF on a minimal 1-pixel frame.
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.frame_cnt_q;
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    check("cnt_preset", {14'd0, frame_cnt_o}, {14'd0, 16'hFFFF});
    pulse_frame(0, 0, 0, 10'd0, 1'b0, "zero_geom");
    check("cnt_wrap", {14'd0, frame_cnt_o}, 30'd0);

    pulse_frame(40, 30, 0, 10'd0, 1'b0, "inc_mod_wrap");

    for (int k = 0; k < 20; k++) begin
      lw = $urandom_range(0, 6);
      ln = $urandom_range(0, 4);
      pulse_frame(lw, ln, $urandom_range(0, 3), 10'($urandom), 1'b1, "random");
      run($urandom_range(0, 3), "random_gap");
    end

    // Reset during the second row: pins clear at once and no done pulse follows.
    set_cfg(4, 3, 0, 10'd0);
    en_i = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 10'd0, 1'b0, 1'b0));
    add_frame(4, 3, 0, 10'd0);
    step("pre_reset");
    en_i = 1'b0;
    run(13, "pre_reset");
    check("pre_reset_href", {29'd0, cpi_href_o}, 30'd1);
    reset = 1'b1;
    #1;
    check("mid_reset", {cpi_vsync_o, cpi_href_o, cpi_data_o, frame_done_o, busy_o, frame_cnt_o}, 30'd0);
    exp_q.delete();
    exp_cnt = '0;
    run(3, "reset_hold");
    reset = 1'b0;
    run(3, "post_reset");
    pulse_frame(2, 1, 1, 10'h0F0, 1'b0, "recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
